pipe_stage_chain: RTL
=====================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised inter-stage pipeline register; next generation of the fixed MW/EM/DE registers.
//  Carries a control bundle and a data bundle through DEPTH register stages, with a valid bit per stage.
//  Adds global stall (hold), per-stage flush (bubble insert), async reset and an occupancy count.
//  Sits between any two CPU stages; DEPTH=1 with MW widths replaces the MW register.
// PARAMETERS
//  CTRL_W  2   control bundle width (MW: {reg_write, mem_to_reg})
//  DATA_W  69  data bundle width (MW: {alu_result[31:0], read_data[31:0], write_reg[4:0]})
//  DEPTH   1   number of register stages, >=1; OCC_W = $clog2(DEPTH+1)
// PORTS
//  clk           in   1          rising-edge clock
//  rst_n         in   1          asynchronous, active-low reset
//  valid_in      in   1          input bundle is a real instruction
//  ctrl_in       in   CTRL_W     control bundle from upstream stage
//  data_in       in   DATA_W     data bundle from upstream stage
//  stall         in   1          hold all stages this cycle
//  flush         in   DEPTH      flush[k]: bubble into stage k this cycle
//  valid_out     out  1          valid bit of last stage
//  ctrl_out      out  CTRL_W     control bundle of last stage
//  data_out      out  DATA_W     data bundle of last stage
//  occupancy     out  OCC_W      number of stages holding valid=1
//  stall_cycles  out  32         only with PIPE_STALL_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low.
//  - rst_n=0: all stage valid/ctrl/data, occupancy (and stall_cycles) go to 0 immediately, no clk needed.
//  - Outputs change only on posedge clk (or on reset assertion); inputs between edges are ignored.
//  - Per edge, per stage k (priority order):
//    1. flush[k]=1 -> valid_k<=0, ctrl_k<=0, data_k<=0 (overrides stall for that stage)
//    2. stall=1    -> stage k holds valid/ctrl/data
//    3. else       -> stage0 <= {valid_in,ctrl_in,data_in}; stage k <= stage k-1
//  - ctrl_in is loaded as-is, even when valid_in=0; ctrl_out is not gated by valid_out.
//  - Latency: DEPTH edges from input to outputs when stall=0; each stall cycle adds one.
//  - Stall+flush same edge: flushed stages bubble; the other stages hold, no shift.
//  - Flush of a stage being shifted into: the flush wins; upstream content is dropped.
//  - The last stage's content leaves on an unstalled edge; there is no downstream backpressure.
//  - occupancy: registered, equals popcount of stage valid bits after the same edge.
//  - Reset mid-stream: all in-flight entries are lost; first edge after release loads stage0 normally.
// CONFIGURATION
//  PIPE_STALL_CNT_EN defined:
//  - port stall_cycles exists.
//  - +1 on each edge with stall=1 and valid_out=1.
//  - saturates at 32'hFFFF_FFFF; cleared only by reset.
//  PIPE_STALL_CNT_EN undefined: port and counter logic absent; everything else identical.
// STRUCTURE
//  Shared package pipe_pkg:
//  - localparams MW_CTRL_W=2, MW_DATA_W=69, EM_*/DE_* widths.
//  - field offsets (MW_ALU_LSB=37, MW_RD_LSB=5, MW_WR_LSB=0).
//  Sub-module pipe_stage: one valid/ctrl/data register with flush>stall>load priority.
//  - instantiated DEPTH times in a generate loop.
//  - occupancy and stall counter live in the top module.
// TESTING
//  1 DEPTH=1 MW: ctrl_in=2'b11, data_in={32'h11111111,32'h99999999,5'd6}, valid_in=1
//    -> outputs 0 before edge; after edge ctrl_out=3, data fields 11111111/99999999/6.
//  2 DEPTH=1: change inputs to 2'b00, {32'h22222222,32'h88888888,5'd1} mid-low phase
//    -> outputs unchanged until next posedge, then 0/22222222/88888888/1.
//  3 DEPTH=3: push A,B,C on 3 edges -> data_out=A after edge 3; occupancy=3;
//    stall 2 edges -> data_out stays A.
//  4 DEPTH=3 full: stall=1, flush=3'b010 -> stage1 bubble, occupancy 3->2;
//    later unstall -> valid_out pattern 1,0,1.
//  5 rst_n low mid-cycle with occupancy=3 -> all outputs 0 at once;
//    after release the first edge loads stage0 only, occupancy=1.
//  6 PIPE_STALL_CNT_EN: 5 stall edges with valid_out=1, plus 2 stall edges with valid_out=0
//    -> stall_cycles=5; force to 32'hFFFFFFFF -> stays there.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: bundle widths
// for the MW/EM/DE stage boundaries, MW field offsets, and the per-stage
// priority decode used by every pipeline register stage.
package pipe_pkg;

    // Memory -> Writeback boundary: {reg_write, mem_to_reg}
    // and {alu_result[31:0], read_data[31:0], write_reg[4:0]}
    localparam int MW_CTRL_W  = 2;
    localparam int MW_DATA_W  = 69;
    localparam int MW_ALU_LSB = 37;
    localparam int MW_RD_LSB  = 5;
    localparam int MW_WR_LSB  = 0;
    localparam int MW_ALU_W   = 32;
    localparam int MW_RD_W    = 32;
    localparam int MW_WR_W    = 5;

    // Execute -> Memory boundary: {reg_write, mem_to_reg, mem_write}
    // and {alu_result[31:0], write_data[31:0], write_reg[4:0]}
    localparam int EM_CTRL_W  = 3;
    localparam int EM_DATA_W  = 69;

    // Decode -> Execute boundary: {reg_write, mem_to_reg, mem_write,
    // alu_ctrl[2:0], alu_src, reg_dst, branch} and
    // {rd1[31:0], rd2[31:0], rs[4:0], rt[4:0], rd[4:0], imm[31:0]}
    localparam int DE_CTRL_W  = 9;
    localparam int DE_DATA_W  = 111;

    // What a single stage does on the next clock edge
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } stage_act_e;

    // Flush beats stall beats load
    function automatic stage_act_e stage_action(input logic flush, input logic stall);
        stage_act_e act;
        if (flush)
            act = ACT_FLUSH;
        else if (stall)
            act = ACT_HOLD;
        else
            act = ACT_LOAD;
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage: valid bit plus control and data bundles.
// Also exposes the valid bit it will hold after the coming edge so the
// parent can keep a registered occupancy count without re-decoding.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = MW_CTRL_W,
    parameter int DATA_W = MW_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic              valid_nxt
);

    stage_act_e        act;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic [DATA_W-1:0] data_nxt;

    // Choose next contents: bubble on flush, keep on stall, else take upstream
    always_comb begin
        act       = stage_action(flush, stall);
        valid_nxt = valid;
        ctrl_nxt  = ctrl;
        data_nxt  = data;
        case (act)
            ACT_FLUSH: begin
                valid_nxt = 1'b0;
                ctrl_nxt  = '0;
                data_nxt  = '0;
            end
            ACT_LOAD: begin
                valid_nxt = valid_in;
                ctrl_nxt  = ctrl_in;
                data_nxt  = data_in;
            end
            default: begin
                valid_nxt = valid;
                ctrl_nxt  = ctrl;
                data_nxt  = data;
            end
        endcase
    end

    // Stage register, cleared immediately on reset assertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else begin
            valid <= valid_nxt;
            ctrl  <= ctrl_nxt;
            data  <= data_nxt;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH pipeline register stages with global stall,
// per-stage flush and a registered occupancy count. DEPTH=1 with the MW
// widths is a drop-in for the old MW register.
// Optional feature macro: PIPE_STALL_CNT_EN adds a saturating 32-bit count
// of stalled edges during which the last stage held a valid entry.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter  int CTRL_W = MW_CTRL_W,
    parameter  int DATA_W = MW_DATA_W,
    parameter  int DEPTH  = 1,
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              stall,
    input  logic [DEPTH-1:0]  flush,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    logic [DEPTH-1:0]  stage_valid;
    logic [DEPTH-1:0]  stage_valid_nxt;
    logic [CTRL_W-1:0] stage_ctrl [DEPTH];
    logic [DATA_W-1:0] stage_data [DEPTH];
    logic [OCC_W-1:0]  occ_nxt;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              up_valid;
        logic [CTRL_W-1:0] up_ctrl;
        logic [DATA_W-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = valid_in;
            assign up_ctrl  = ctrl_in;
            assign up_data  = data_in;
        end else begin : g_body
            assign up_valid = stage_valid[k-1];
            assign up_ctrl  = stage_ctrl[k-1];
            assign up_data  = stage_data[k-1];
        end

        pipe_stage #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[k]),
            .stall     (stall),
            .valid_in  (up_valid),
            .ctrl_in   (up_ctrl),
            .data_in   (up_data),
            .valid     (stage_valid[k]),
            .ctrl      (stage_ctrl[k]),
            .data      (stage_data[k]),
            .valid_nxt (stage_valid_nxt[k])
        );
    end

    assign valid_out = stage_valid[DEPTH-1];
    assign ctrl_out  = stage_ctrl[DEPTH-1];
    assign data_out  = stage_data[DEPTH-1];

    // Count the valid bits the stages will hold after this edge
    always_comb begin
        occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_nxt = occ_nxt + OCC_W'(stage_valid_nxt[k]);
        end
    end

    // Occupancy register, in step with the stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            occupancy <= '0;
        else
            occupancy <= occ_nxt;
    end

`ifdef PIPE_STALL_CNT_EN
    // Count stalled edges that hold back a real instruction; sticks at max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall && valid_out && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
